// File: rtl/fft_input_reorder.sv
// fft_input_reorder
//   Collects natural-order complex samples into one of two ping-pong banks and,
//   once a bank holds a full frame, streams it out as radix-2 butterfly operand
//   pairs in bit-reversed order: pair k carries A = x[bitrev(2k)] and
//   B = x[bitrev(2k)+N/2].
//
//   Each bank is split into a low half (addresses 0..N/2-1) and a high half
//   (N/2..N-1). bitrev(2k) always has its MSB clear, so A always lives in the
//   low half and B in the high half at the same offset, which is bitrev(k)
//   over LOG2N-1 bits. That gives one read per half per cycle.
//
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   in_re, in_im, in_valid          natural-order input sample
//   in_ready                        sample accepted when in_valid && in_ready
//   out_a_re/im, out_b_re/im        butterfly operand pair
//   out_valid, out_ready            pair handshake
//   out_first, out_last, out_idx    pair 0 / pair N/2-1 markers, pair index k
module fft_input_reorder #(
  parameter int WIDTH = 16,
  parameter int N     = 64,
  localparam int LOG2N = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [WIDTH-1:0] in_re,
  input  logic signed [WIDTH-1:0] in_im,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [WIDTH-1:0] out_a_re,
  output logic signed [WIDTH-1:0] out_a_im,
  output logic signed [WIDTH-1:0] out_b_re,
  output logic signed [WIDTH-1:0] out_b_im,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_first,
  output logic                    out_last,
  output logic [LOG2N-2:0]        out_idx
);

  localparam int KW   = LOG2N - 1;
  localparam int HALF = N / 2;

  typedef enum logic {IDLE, RUN} rd_state_t;

  // Storage indexed by {bank, offset-within-half}.
  logic [2*WIDTH-1:0] mem_lo [N];
  logic [2*WIDTH-1:0] mem_hi [N];

  logic             wr_bank;
  logic [LOG2N-1:0] wr_addr;
  logic [1:0]       full;
  logic             rd_bank;
  logic [KW-1:0]    rd_k;
  rd_state_t        state;
  logic             out_bank;

  logic             accept;
  logic             wr_last;
  logic             load;
  logic             k_last;
  logic [1:0]       set_vec;
  logic [1:0]       clr_vec;
  logic [KW-1:0]    rd_off;
  logic [2*WIDTH-1:0] rd_lo;
  logic [2*WIDTH-1:0] rd_hi;

  function automatic logic [KW-1:0] bitrev_k(input logic [KW-1:0] k);
    logic [KW-1:0] r;
    for (int i = 0; i < KW; i++) r[i] = k[KW-1-i];
    return r;
  endfunction

  assign in_ready = rst_n && !full[wr_bank];
  assign accept   = in_valid && in_ready;
  assign wr_last  = (wr_addr == LOG2N'(N-1));
  assign load     = (state == RUN) && (!out_valid || out_ready);
  assign k_last   = (rd_k == KW'(HALF-1));
  assign rd_off   = bitrev_k(rd_k);
  assign rd_lo    = mem_lo[{rd_bank, rd_off}];
  assign rd_hi    = mem_hi[{rd_bank, rd_off}];

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (accept && wr_last) set_vec[wr_bank] = 1'b1;
    // A bank is released when its final pair leaves the output register.
    if (out_valid && out_ready && out_last) clr_vec[out_bank] = 1'b1;
  end

  // ---- write stage: sample into bank half selected by address MSB ----
  always_ff @(posedge clk) begin
    if (accept) begin
      if (!wr_addr[LOG2N-1]) mem_lo[{wr_bank, wr_addr[KW-1:0]}] <= {in_re, in_im};
      else                   mem_hi[{wr_bank, wr_addr[KW-1:0]}] <= {in_re, in_im};
    end
  end

  // ---- control and output register stage ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bank   <= 1'b0;
      wr_addr   <= '0;
      full      <= '0;
      rd_bank   <= 1'b0;
      rd_k      <= '0;
      state     <= IDLE;
      out_bank  <= 1'b0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      out_idx   <= '0;
      out_a_re  <= '0;
      out_a_im  <= '0;
      out_b_re  <= '0;
      out_b_im  <= '0;
    end else begin
      full <= (full | set_vec) & ~clr_vec;

      if (accept) begin
        wr_addr <= wr_addr + LOG2N'(1);
        // Always flip; in_ready stays low until the new target bank frees up.
        if (wr_last) wr_bank <= ~wr_bank;
      end

      // Banks fill and drain in the same 0,1,0,1 order, so the reader only
      // ever needs to look at rd_bank (or its partner when finishing a frame).
      case (state)
        IDLE: if (full[rd_bank]) state <= RUN;
        RUN: begin
          if (load) begin
            if (k_last) begin
              rd_bank <= ~rd_bank;
              rd_k    <= '0;
              // Counting a bank that completes on this same edge avoids a bubble.
              if (!(full[~rd_bank] || set_vec[~rd_bank])) state <= IDLE;
            end else begin
              rd_k <= rd_k + KW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (load) begin
        out_valid <= 1'b1;
        out_first <= (rd_k == '0);
        out_last  <= k_last;
        out_idx   <= rd_k;
        out_bank  <= rd_bank;
        out_a_re  <= rd_lo[2*WIDTH-1:WIDTH];
        out_a_im  <= rd_lo[WIDTH-1:0];
        out_b_re  <= rd_hi[2*WIDTH-1:WIDTH];
        out_b_im  <= rd_hi[WIDTH-1:0];
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_first <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_input_reorder.sv
// Bench for fft_input_reorder: an N=8 instance exercised with directed
// scenarios and an N=1024 instance with random data and handshakes. A
// reference model collects each accepted frame and predicts its pairs from
// the bit-reversal rule directly.
module tb_fft_input_reorder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rev(input int v, input int bits);
    int r;
    r = 0;
    for (int i = 0; i < bits; i++) r = (r << 1) | ((v >> i) & 1);
    return r;
  endfunction

  // ------------------------------------------------------------ N = 8
  logic               a_rst_n = 1'b0;
  logic signed [15:0] a_in_re = '0, a_in_im = '0;
  logic               a_in_valid = 1'b0, a_in_ready;
  logic signed [15:0] a_out_a_re, a_out_a_im, a_out_b_re, a_out_b_im;
  logic               a_out_valid, a_out_ready = 1'b0, a_out_first, a_out_last;
  logic [1:0]         a_out_idx;

  fft_input_reorder #(.WIDTH(16), .N(8)) u_a (
    .clk(clk), .rst_n(a_rst_n), .in_re(a_in_re), .in_im(a_in_im),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_a_re(a_out_a_re), .out_a_im(a_out_a_im), .out_b_re(a_out_b_re), .out_b_im(a_out_b_im),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_first(a_out_first),
    .out_last(a_out_last), .out_idx(a_out_idx)
  );

  wire [63:0] a_cur_d = {a_out_a_re, a_out_a_im, a_out_b_re, a_out_b_im};
  wire [4:0]  a_cur_c = {a_out_valid, a_out_first, a_out_last, a_out_idx};

  logic [31:0] a_buf[$];
  logic [63:0] a_exp[$];
  int          a_expk[$];
  int          a_pairs = 0, a_stalls = 0;
  logic        a_held = 1'b0;
  logic [63:0] a_prev_d;
  logic [4:0]  a_prev_c;

  always @(negedge clk) begin
    if (!a_rst_n) begin
      a_buf.delete(); a_exp.delete(); a_expk.delete(); a_held = 1'b0;
    end else begin
      if (a_held) begin
        chk("a_hold_data", a_cur_d, a_prev_d);
        chk("a_hold_ctrl", a_cur_c, a_prev_c);
      end
      a_held = a_out_valid && !a_out_ready;
      a_prev_d = a_cur_d;
      a_prev_c = a_cur_c;
      if (a_out_valid && a_out_ready) begin
        if (a_exp.size() == 0) chk("a_spurious_pair", a_out_valid, 0);
        else begin
          int k;
          k = a_expk.pop_front();
          chk("a_pair", a_cur_d, a_exp.pop_front());
          chk("a_idx", a_out_idx, k);
          chk("a_first", a_out_first, k == 0);
          chk("a_last", a_out_last, k == 3);
          a_pairs++;
        end
      end
      if (a_in_valid && !a_in_ready) a_stalls++;
      if (a_in_valid && a_in_ready) begin
        a_buf.push_back({a_in_re, a_in_im});
        if (a_buf.size() == 8) begin
          for (int k = 0; k < 4; k++) begin
            a_exp.push_back({a_buf[rev(2*k, 3)], a_buf[rev(2*k+1, 3)]});
            a_expk.push_back(k);
          end
          a_buf.delete();
        end
      end
    end
  end

  int   a_rdy_mode = 0;
  logic a_rdy_hold = 1'b1;
  int   a_pat = 0;
  always @(posedge clk) begin
    #1;
    case (a_rdy_mode)
      0: a_out_ready = a_rdy_hold;
      1: begin a_out_ready = (a_pat == 0); a_pat = (a_pat + 1) % 3; end
      default: a_out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic a_push(input logic [15:0] re, input logic [15:0] im);
    int t;
    t = 0;
    a_in_re = re; a_in_im = im; a_in_valid = 1'b1;
    @(negedge clk);
    while (!a_in_ready && t < 500) begin @(negedge clk); t++; end
    if (t >= 500) chk("a_push_timeout", a_in_ready, 1);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic a_drain();
    int t;
    t = 0;
    while ((a_exp.size() != 0 || a_out_valid) && t < 300) begin @(negedge clk); t++; end
    chk("a_drain", a_exp.size(), 0);
    @(posedge clk); #1;
  endtask

  // ------------------------------------------------------------ N = 1024
  logic               b_rst_n = 1'b0;
  logic signed [15:0] b_in_re = '0, b_in_im = '0;
  logic               b_in_valid = 1'b0, b_in_ready;
  logic signed [15:0] b_out_a_re, b_out_a_im, b_out_b_re, b_out_b_im;
  logic               b_out_valid, b_out_ready = 1'b0, b_out_first, b_out_last;
  logic [8:0]         b_out_idx;

  fft_input_reorder #(.WIDTH(16), .N(1024)) u_b (
    .clk(clk), .rst_n(b_rst_n), .in_re(b_in_re), .in_im(b_in_im),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_a_re(b_out_a_re), .out_a_im(b_out_a_im), .out_b_re(b_out_b_re), .out_b_im(b_out_b_im),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_first(b_out_first),
    .out_last(b_out_last), .out_idx(b_out_idx)
  );

  wire [63:0] b_cur_d = {b_out_a_re, b_out_a_im, b_out_b_re, b_out_b_im};
  wire [11:0] b_cur_c = {b_out_valid, b_out_first, b_out_last, b_out_idx};

  logic [31:0] b_buf[$];
  logic [63:0] b_exp[$];
  int          b_expk[$];
  int          b_pairs = 0;
  logic        b_held = 1'b0;
  logic [63:0] b_prev_d;
  logic [11:0] b_prev_c;

  always @(negedge clk) begin
    if (!b_rst_n) begin
      b_buf.delete(); b_exp.delete(); b_expk.delete(); b_held = 1'b0;
    end else begin
      if (b_held) begin
        chk("b_hold_data", b_cur_d, b_prev_d);
        chk("b_hold_ctrl", b_cur_c, b_prev_c);
      end
      b_held = b_out_valid && !b_out_ready;
      b_prev_d = b_cur_d;
      b_prev_c = b_cur_c;
      if (b_out_valid && b_out_ready) begin
        if (b_exp.size() == 0) chk("b_spurious_pair", b_out_valid, 0);
        else begin
          int k;
          k = b_expk.pop_front();
          chk("b_pair", b_cur_d, b_exp.pop_front());
          chk("b_idx", b_out_idx, k);
          chk("b_first", b_out_first, k == 0);
          chk("b_last", b_out_last, k == 511);
          b_pairs++;
        end
      end
      if (b_in_valid && b_in_ready) begin
        b_buf.push_back({b_in_re, b_in_im});
        if (b_buf.size() == 1024) begin
          for (int k = 0; k < 512; k++) begin
            b_exp.push_back({b_buf[rev(2*k, 10)], b_buf[rev(2*k+1, 10)]});
            b_expk.push_back(k);
          end
          b_buf.delete();
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    b_out_ready = 1'($urandom_range(0, 1));
  end

  task automatic b_push(input logic [15:0] re, input logic [15:0] im);
    int t;
    t = 0;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    b_in_re = re; b_in_im = im; b_in_valid = 1'b1;
    @(negedge clk);
    while (!b_in_ready && t < 5000) begin @(negedge clk); t++; end
    if (t >= 5000) chk("b_push_timeout", b_in_ready, 1);
    @(posedge clk); #1;
    b_in_valid = 1'b0;
  endtask

  // ------------------------------------------------------------ sequence
  initial begin
    int p;
    repeat (3) @(posedge clk);
    #1;
    chk("a_rst_in_ready", a_in_ready, 0);
    chk("a_rst_out_valid", a_out_valid, 0);
    chk("a_rst_out_data", a_cur_d, 0);
    chk("a_rst_out_ctrl", {a_out_first, a_out_last, a_out_idx}, 0);
    a_rst_n = 1'b1;
    #1 chk("a_ready_after_rst", a_in_ready, 1);
    @(posedge clk); #1;

    // Ramp frame x[i] = (i, -i); first pair 2 edges after x[7] is accepted.
    a_rdy_mode = 0; a_rdy_hold = 1'b1;
    for (int i = 0; i < 8; i++) a_push(16'(i), 16'(-i));
    chk("a_lat_edge0", a_out_valid, 0);
    @(posedge clk); #1;
    chk("a_lat_edge1", a_out_valid, 0);
    @(posedge clk); #1;
    chk("a_lat_edge2", a_out_valid, 1);
    chk("a_ramp_pair0", a_cur_d, 64'h0000_0000_0004_fffc);
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; chk("a_ramp_stream", a_out_valid, 1); end
    @(posedge clk); #1;
    chk("a_ramp_end", a_out_valid, 0);
    a_drain();

    // out_ready toggling 1,0,0: pairs must hold while stalled.
    p = a_pairs;
    a_rdy_mode = 1;
    for (int i = 0; i < 16; i++) a_push(16'($urandom), 16'($urandom));
    a_drain();
    chk("a_toggle_pairs", a_pairs - p, 8);

    // Stalled output: two frames fill both banks, then back-to-back drain.
    a_rdy_mode = 0; a_rdy_hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) a_push(16'($urandom), 16'($urandom));
    chk("a_full_in_ready", a_in_ready, 0);
    chk("a_full_out_valid", a_out_valid, 1);
    a_rdy_hold = 1'b1;
    p = 0;
    @(negedge clk);
    while (!a_out_ready && p < 10) begin @(negedge clk); p++; end
    for (int i = 0; i < 8; i++) begin chk("a_b2b_valid", a_out_valid, 1); @(negedge clk); end
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) a_push(16'($urandom), 16'($urandom));
    a_drain();

    // Ten continuous frames with out_ready high: no input stall.
    p = a_pairs;
    a_stalls = 0;
    for (int i = 0; i < 80; i++) a_push(16'($urandom), 16'($urandom));
    a_drain();
    chk("a_cont_no_stall", a_stalls, 0);
    chk("a_cont_pairs", a_pairs - p, 40);

    // Reset after 5 samples: partial frame discarded.
    p = a_pairs;
    for (int i = 0; i < 5; i++) a_push(16'($urandom), 16'($urandom));
    a_rst_n = 1'b0;
    #1 chk("a_mid_rst_in_ready", a_in_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("a_mid_rst_out_valid", a_out_valid, 0);
    a_rst_n = 1'b1;
    #1 chk("a_mid_rst_ready_back", a_in_ready, 1);
    for (int i = 0; i < 6; i++) begin @(posedge clk); #1; chk("a_no_stale", a_out_valid, 0); end
    for (int i = 0; i < 8; i++) a_push(16'($urandom), 16'($urandom));
    a_drain();
    chk("a_post_rst_pairs", a_pairs - p, 4);

    // Large frame size with random data and handshakes.
    b_rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3 * 1024; i++) b_push(16'($urandom), 16'($urandom));
    p = 0;
    while ((b_exp.size() != 0 || b_out_valid) && p < 3000) begin @(negedge clk); p++; end
    chk("b_drain", b_exp.size(), 0);
    chk("b_pairs", b_pairs, 1536);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fft_input_reorder.md
FFT_INPUT_REORDER -- requirements
Module: fft_input_reorder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the signed two's-complement width of each real/imag component (Q1.15 at default).
REQ-002 SHALL have parameter N, default 64, giving FFT points per frame; legal values are powers of two from 4 to 1024; LOG2N = log2(N) is derived.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst_n, input, 1, reset, synchronous, active-low.
REQ-005 SHALL have ports in_re and in_im, input, WIDTH each, signed natural-order time sample.
REQ-006 SHALL have port in_valid, input, 1, sample present.
REQ-007 SHALL have port in_ready, output, 1, block accepts the sample this cycle.
REQ-008 SHALL have ports out_a_re, out_a_im, out_b_re, out_b_im, output, WIDTH each, forming the butterfly A/B operand pair.
REQ-009 SHALL have port out_valid, output, 1, pair present.
REQ-010 SHALL have port out_ready, input, 1, downstream butterfly stage accepts the pair.
REQ-011 SHALL have port out_first, output, 1, marking pair 0 of a frame.
REQ-012 SHALL have port out_last, output, 1, marking pair N/2-1 of a frame.
REQ-013 SHALL have port out_idx, output, LOG2N-1, giving pair index k.

Function
REQ-014 SHALL transfer an input sample when in_valid and in_ready are both high on a rising clk edge, and transfer an output pair when out_valid and out_ready are both high.
REQ-015 SHALL contain two ping-pong banks of N complex words each; the write side fills one bank at addresses 0..N-1 in arrival order.
REQ-016 SHALL mark a bank FULL on the Nth accepted sample, with the write side advancing to the other bank if that bank is FREE.
REQ-017 SHALL drive in_ready low while the write-target bank is FULL (both banks FULL) and high otherwise, outside reset.
REQ-018 SHALL run a read FSM with states IDLE and RUN: IDLE -> RUN when a FULL bank exists; RUN -> IDLE after pair N/2-1 transfers and no other bank is FULL; RUN -> RUN (next bank, no bubble) when the other bank is already FULL.
REQ-019 SHALL, for pair k (0..N/2-1), output A = x[bitrev(2k)] and B = x[bitrev(2k+1)] = x[bitrev(2k)+N/2], where bitrev reverses LOG2N bits.
REQ-020 SHALL return a bank to FREE in the cycle its last pair transfers; a write into that bank SHALL be legal the following cycle.
REQ-021 SHALL assert out_valid exactly 2 cycles after the edge that accepts sample N-1 when the read FSM is IDLE.
REQ-022 SHALL hold all out_* stable while out_valid is high and out_ready is low.
REQ-023 SHALL sustain one pair per cycle with out_ready held high, and one sample per cycle with in_valid held high (no input stall when out_ready is high at least 50% of cycles).
REQ-024 SHALL assert out_first only with k=0 and out_last only with k=N/2-1, both qualified by out_valid.
REQ-025 SHALL pass data bit-exactly with no scaling, rounding or saturation.
REQ-026 SHALL preserve correct data when a sample is written and a pair is read in the same cycle (different banks).

Reset
REQ-027 SHALL, on an edge with rst_n low, set both banks FREE, the read FSM to IDLE, the write pointer to bank 0 address 0, and out_valid, out_first, out_last, out_idx and all out data to 0.
REQ-028 SHALL hold in_ready at 0 while rst_n is low and at 1 on the first cycle after release.
REQ-029 SHALL discard partial frames and in-flight pairs on reset asserted mid-operation, with no output appearing after reset until N new samples are accepted.
REQ-030 SHALL not require bank RAM contents to be cleared.

Verification
REQ-031 SHALL be verified with N=8 and input x[i] = (i, -i) for i=0..7 with out_ready high -> pairs (0,4),(2,6),(1,5),(3,7) on consecutive cycles, im negated, out_first on pair 0, out_last on pair 3, out_valid 2 cycles after x[7].
REQ-032 SHALL be verified with N=8 and out_ready toggling 1,0,0,1,... -> each pair held stable while stalled, with no pair lost or duplicated.
REQ-033 SHALL be verified with N=8 and out_ready held low while feeding 3 frames -> frames 1 and 2 fill the banks, in_ready drops after the 16th sample, and releasing out_ready yields frame 1 then frame 2 back-to-back with no bubble.
REQ-034 SHALL be verified with N=8, continuous input and out_ready high for 10 frames -> in_ready never drops and every frame's output matches the bit-reverse model.
REQ-035 SHALL be verified with N=8, rst_n pulsed low after 5 samples -> out_valid stays 0 and the next 8 samples produce a correct frame with no stale data.
REQ-036 SHALL be verified with N=1024 and random data and random handshakes -> output matches the scoreboard bit-exactly.
